// File: rtl/alu_exmem_stage.sv
// EX->MEM pipeline register behind the 64-bit ALU: owns the NZCV flags and registers the branch decision.
// Optional saturating perf counters are built only when EXMEM_PERF_CNT_EN is defined.
module alu_exmem_stage #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    input  logic              set_flags,
    input  logic              is_bcond,
    input  logic [3:0]        cond,
    input  logic              is_cbz,
    input  logic              cbnz,
    input  logic [RD_W-1:0]   rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] store_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] out_store_data,
    output logic              out_branch_taken,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  perf_retired,
    output logic [CNT_W-1:0]  perf_taken
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic              branch_taken_q, branch_taken_d;
    logic [3:0]        flags_d;
    logic              cond_true;
    logic              branch_taken;
    logic              accept;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // B.cond always sees the flags as they stood before this instruction.
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            4'd0:    cond_true = flags_q[2];
            4'd1:    cond_true = !flags_q[2];
            4'd2:    cond_true = flags_q[1];
            4'd3:    cond_true = !flags_q[1];
            4'd4:    cond_true = flags_q[3];
            4'd5:    cond_true = !flags_q[3];
            4'd6:    cond_true = flags_q[0];
            4'd7:    cond_true = !flags_q[0];
            4'd8:    cond_true = flags_q[1] && !flags_q[2];
            4'd9:    cond_true = !(flags_q[1] && !flags_q[2]);
            4'd10:   cond_true = (flags_q[3] == flags_q[0]);
            4'd11:   cond_true = (flags_q[3] != flags_q[0]);
            4'd12:   cond_true = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'd13:   cond_true = !(!flags_q[2] && (flags_q[3] == flags_q[0]));
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        if (is_bcond) begin
            branch_taken = cond_true;
        end else if (is_cbz) begin
            branch_taken = alu_zero ^ cbnz;
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        result_d       = result_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        store_data_d   = store_data_q;
        branch_taken_d = branch_taken_q;
        flags_d        = flags_q;
        if (flush) begin
            out_valid_d    = 1'b0;
            branch_taken_d = 1'b0;
        end else if (accept) begin
            out_valid_d    = 1'b1;
            result_d       = alu_result;
            rd_d           = rd;
            reg_write_d    = reg_write;
            mem_read_d     = mem_read;
            mem_write_d    = mem_write;
            store_data_d   = store_data;
            branch_taken_d = branch_taken;
            if (set_flags) begin
                flags_d = {alu_negative, alu_zero, alu_carry, alu_overflow};
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            result_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            store_data_q   <= '0;
            branch_taken_q <= 1'b0;
            flags_q        <= 4'b0000;
        end else begin
            out_valid_q    <= out_valid_d;
            result_q       <= result_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            store_data_q   <= store_data_d;
            branch_taken_q <= branch_taken_d;
            flags_q        <= flags_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_result       = result_q;
    assign out_rd           = rd_q;
    assign out_reg_write    = reg_write_q;
    assign out_mem_read     = mem_read_q;
    assign out_mem_write    = mem_write_q;
    assign out_store_data   = store_data_q;
    assign out_branch_taken = branch_taken_q;

`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0] perf_retired_q, perf_retired_d;
    logic [CNT_W-1:0] perf_taken_q, perf_taken_d;
    logic             handshake;

    // A flush cycle never counts, even if MEM happened to be ready.
    always_comb begin
        handshake      = out_valid_q && out_ready && !flush;
        perf_retired_d = perf_retired_q;
        perf_taken_d   = perf_taken_q;
        if (handshake && (perf_retired_q != '1)) begin
            perf_retired_d = perf_retired_q + CNT_W'(1);
        end
        if (handshake && branch_taken_q && (perf_taken_q != '1)) begin
            perf_taken_d = perf_taken_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired_q <= '0;
            perf_taken_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_taken_q   <= perf_taken_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_taken   = perf_taken_q;
`else
    assign perf_retired = '0;
    assign perf_taken   = '0;
`endif

endmodule
